// File: rtl/izhikevich_state_update.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : izhikevich_state_update                                     |
// | Description : Izhikevich neuron state-update stage: saturates v_next,     |
// |               updates u, detects spikes and applies the (c, d) reset.     |
// |               Optional refractory hold selected by macro REFRACTORY_EN.   |
// | Revision    : 1.0 - initial release                                       |
// +--------------------------------------------------------------------------+
module izhikevich_state_update #(
    parameter int V_PEAK       = 30,
    parameter int V_INIT       = -65,
    parameter int U_INIT       = -13,
    parameter int REFRAC_STEPS = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic signed [31:0] v_next_in,
    input  logic signed [15:0] dt_in,
    input  logic signed [15:0] a_q,
    input  logic signed [15:0] b_q,
    input  logic signed [15:0] c_in,
    input  logic signed [15:0] d_in,
    output logic signed [15:0] v_out,
    output logic signed [15:0] u_out,
    output logic               spike,
    output logic               out_valid,
    output logic        [15:0] spike_count
);

    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_CALC   = 2'd1;
    localparam logic [1:0] c_COMMIT = 2'd2;

    localparam logic signed [15:0] c_V_PEAK = 16'(V_PEAK);
    localparam logic signed [15:0] c_V_INIT = 16'(V_INIT);
    localparam logic signed [15:0] c_U_INIT = 16'(U_INIT);

    logic        [1:0]  r_state;
    logic signed [15:0] r_vs;
    logic signed [15:0] r_dt;
    logic signed [15:0] r_a;
    logic signed [15:0] r_b;
    logic signed [15:0] r_c;
    logic signed [15:0] r_d;
    logic signed [47:0] r_un;

    logic signed [15:0] w_vs;
    logic signed [31:0] w_b32;
    logic signed [31:0] w_v32;
    logic signed [31:0] w_u32;
    logic signed [31:0] w_bv;
    logic signed [31:0] w_diff;
    logic signed [47:0] w_a48;
    logic signed [47:0] w_diff48;
    logic signed [47:0] w_du_prod;
    logic signed [31:0] w_du;
    logic signed [47:0] w_du48;
    logic signed [47:0] w_dt48;
    logic signed [47:0] w_u48;
    logic signed [47:0] w_un;
    logic signed [47:0] w_un_d;
    logic               w_thr;

    function automatic logic signed [15:0] f_clamp16(input logic signed [47:0] x);
        if (x > 48'sd32767)
            f_clamp16 = 16'sh7FFF;
        else if (x < -48'sd32768)
            f_clamp16 = 16'sh8000;
        else
            f_clamp16 = x[15:0];
    endfunction

    assign in_ready = (r_state == c_IDLE);

    always_comb begin
        w_vs = v_next_in[15:0];
        if (v_next_in > 32'sd32767)
            w_vs = 16'sh7FFF;
        else if (v_next_in < -32'sd32768)
            w_vs = 16'sh8000;
    end

    // u update uses the state still held in v_out/u_out (the old step)
    assign w_b32     = {{16{r_b[15]}}, r_b};
    assign w_v32     = {{16{v_out[15]}}, v_out};
    assign w_u32     = {{16{u_out[15]}}, u_out};
    assign w_bv      = (w_b32 * w_v32) >>> 8;
    assign w_diff    = w_bv - w_u32;
    assign w_a48     = {{32{r_a[15]}}, r_a};
    assign w_diff48  = {{16{w_diff[31]}}, w_diff};
    assign w_du_prod = w_a48 * w_diff48;
    assign w_du      = 32'(w_du_prod >>> 8);
    assign w_du48    = {{16{w_du[31]}}, w_du};
    assign w_dt48    = {{32{r_dt[15]}}, r_dt};
    assign w_u48     = {{32{u_out[15]}}, u_out};
    assign w_un      = w_u48 + w_du48 * w_dt48;
    assign w_un_d    = r_un + {{32{r_d[15]}}, r_d};
    assign w_thr     = (r_vs >= c_V_PEAK);

`ifdef REFRACTORY_EN
    localparam logic [2:0] c_REFRAC = 3'(REFRAC_STEPS);
    logic [2:0] r_refrac;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= c_IDLE;
            r_vs        <= '0;
            r_dt        <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_c         <= '0;
            r_d         <= '0;
            r_un        <= '0;
            v_out       <= c_V_INIT;
            u_out       <= c_U_INIT;
            spike       <= 1'b0;
            out_valid   <= 1'b0;
            spike_count <= '0;
`ifdef REFRACTORY_EN
            r_refrac    <= '0;
`endif
        end else begin
            spike     <= 1'b0;
            out_valid <= 1'b0;
            case (r_state)
                c_IDLE: begin
                    if (in_valid) begin
                        r_vs    <= w_vs;
                        r_dt    <= dt_in;
                        r_a     <= a_q;
                        r_b     <= b_q;
                        r_c     <= c_in;
                        r_d     <= d_in;
                        r_state <= c_CALC;
                    end
                end
                c_CALC: begin
                    r_un    <= w_un;
                    r_state <= c_COMMIT;
                end
                c_COMMIT: begin
                    out_valid <= 1'b1;
                    r_state   <= c_IDLE;
`ifdef REFRACTORY_EN
                    if (r_refrac != 3'd0) begin
                        v_out    <= r_c;
                        u_out    <= f_clamp16(r_un);
                        r_refrac <= r_refrac - 3'd1;
                    end else if (w_thr) begin
                        v_out       <= r_c;
                        u_out       <= f_clamp16(w_un_d);
                        spike       <= 1'b1;
                        spike_count <= spike_count + 16'd1;
                        r_refrac    <= c_REFRAC;
                    end else begin
                        v_out <= r_vs;
                        u_out <= f_clamp16(r_un);
                    end
`else
                    if (w_thr) begin
                        v_out       <= r_c;
                        u_out       <= f_clamp16(w_un_d);
                        spike       <= 1'b1;
                        spike_count <= spike_count + 16'd1;
                    end else begin
                        v_out <= r_vs;
                        u_out <= f_clamp16(r_un);
                    end
`endif
                end
                default: r_state <= c_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_izhikevich_state_update.sv
`default_nettype none
// Randomized self-checking bench for izhikevich_state_update against an
// arithmetic reference model of the neuron update rules.
module tb_izhikevich_state_update;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               in_valid = 1'b0;
    logic               in_ready;
    logic signed [31:0] v_next_in = '0;
    logic signed [15:0] dt_in = '0;
    logic signed [15:0] a_q = '0;
    logic signed [15:0] b_q = '0;
    logic signed [15:0] c_in = '0;
    logic signed [15:0] d_in = '0;
    logic signed [15:0] v_out;
    logic signed [15:0] u_out;
    logic               spike;
    logic               out_valid;
    logic        [15:0] spike_count;

    izhikevich_state_update #(
        .V_PEAK(30), .V_INIT(-65), .U_INIT(-13), .REFRAC_STEPS(2)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .v_next_in(v_next_in), .dt_in(dt_in), .a_q(a_q), .b_q(b_q),
        .c_in(c_in), .d_in(d_in), .v_out(v_out), .u_out(u_out),
        .spike(spike), .out_valid(out_valid), .spike_count(spike_count)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    longint m_v, m_u, m_cnt;
    int     m_ref;

    typedef struct {
        longint v;
        longint u;
        longint sp;
        longint cnt;
    } exp_t;

    function automatic longint clamp16(input longint x);
        if (x > 32767) return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic longint floor256(input longint x);
        if (x >= 0) return x / 256;
        return -((-x + 255) / 256);
    endfunction

    task automatic model_reset();
        m_v = -65; m_u = -13; m_cnt = 0; m_ref = 0;
    endtask

    task automatic model_step(input longint vn, input longint dt, input longint a,
                              input longint b, input longint c, input longint d,
                              output exp_t e);
        longint vs, du, un;
        bit     spk;
        vs  = clamp16(vn);
        du  = floor256(a * (floor256(b * m_v) - m_u));
        un  = m_u + du * dt;
        spk = 0;
        if (m_ref > 0) begin
            m_v = c; m_u = clamp16(un); m_ref--;
        end else if (vs >= 30) begin
            m_v = c; m_u = clamp16(un + d); spk = 1;
            m_cnt = (m_cnt + 1) % 65536;
`ifdef REFRACTORY_EN
            m_ref = 2;
`endif
        end else begin
            m_v = vs; m_u = clamp16(un);
        end
        e.v = m_v; e.u = m_u; e.sp = longint'(spk); e.cnt = m_cnt;
    endtask

    task automatic compare_out(input string tag, input exp_t e);
        check({tag, "_v"}, longint'(v_out), e.v);
        check({tag, "_u"}, longint'(u_out), e.u);
        check({tag, "_spike"}, longint'(spike), e.sp);
        check({tag, "_count"}, longint'(spike_count), e.cnt);
    endtask

    task automatic drive(input longint vn, input longint dt, input longint a,
                         input longint b, input longint c, input longint d);
        v_next_in = 32'(vn); dt_in = 16'(dt); a_q = 16'(a);
        b_q = 16'(b); c_in = 16'(c); d_in = 16'(d);
    endtask

    task automatic do_step(input string tag, input longint vn, input longint dt,
                           input longint a, input longint b, input longint c,
                           input longint d);
        exp_t e;
        int   cyc;
        bit   seen;
        @(negedge clk);
        check({tag, "_ready_idle"}, longint'(in_ready), 1);
        drive(vn, dt, a, b, c, d);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        // scrambled inputs after accept must not affect the step
        drive(longint'($urandom), $urandom_range(0, 100), $urandom_range(0, 255),
              $urandom_range(0, 255), $urandom_range(0, 99), $urandom_range(0, 99));
        model_step(vn, dt, a, b, c, d, e);
        check({tag, "_ready_busy"}, longint'(in_ready), 0);
        cyc  = 0;
        seen = 0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(negedge clk);
            if (out_valid) seen = 1;
            else begin
                @(posedge clk);
                cyc++;
            end
        end
        check({tag, "_latency"}, seen ? cyc : -1, 2);
        compare_out(tag, e);
        @(negedge clk);
        check({tag, "_valid_pulse"}, longint'(out_valid), 0);
        check({tag, "_spike_pulse"}, longint'(spike), 0);
    endtask

    exp_t q[$];

    initial begin
        exp_t   e;
        int     acc;
        int     ov_seen;
        longint cnt0;
        longint vn;
        int     r;

        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_v", longint'(v_out), -65);
        check("rst_u", longint'(u_out), -13);
        check("rst_count", longint'(spike_count), 0);
        check("rst_ready", longint'(in_ready), 1);
        check("rst_valid", longint'(out_valid), 0);
        check("rst_spike", longint'(spike), 0);

        do_step("sub", -60, 1, 5, 51, -65, 3);
        check("sub_v_direct", longint'(v_out), -60);

        do_step("spk", 35, 1, 5, 51, -65, 8);
        check("spk_v_direct", longint'(v_out), -65);

        do_step("sat_pos", 32'h0001_0000, 1, 5, 51, -65, 8);
        do_step("sat_neg", -100000, 1, 5, 51, -65, 8);

        // back-to-back with in_valid held high
        acc = 0;
        @(negedge clk);
        drive(-50, 1, 2, 51, -65, 8);
        in_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            if (out_valid) begin
                if (q.size() == 0) check("b2b_unexpected_valid", 1, 0);
                else begin
                    e = q.pop_front();
                    compare_out("b2b", e);
                end
            end
            if (in_ready) begin
                model_step(-50, 1, 2, 51, -65, 8, e);
                q.push_back(e);
                acc++;
            end
        end
        in_valid = 1'b0;
        for (int i = 0; i < 6 && q.size() > 0; i++) begin
            @(negedge clk);
            if (out_valid) begin
                e = q.pop_front();
                compare_out("b2b_drain", e);
            end
        end
        check("b2b_accepts", acc, 3);
        check("b2b_drained", q.size(), 0);

        // reset during CALC discards the in-flight step
        @(negedge clk);
        drive(40, 1, 5, 51, -70, 8);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst = 1'b1;
        #1;
        check("rst_mid_valid", longint'(out_valid), 0);
        check("rst_mid_v", longint'(v_out), -65);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        ov_seen = 0;
        repeat (5) begin
            @(negedge clk);
            if (out_valid) ov_seen++;
        end
        check("rst_mid_no_valid", ov_seen, 0);
        check("rst_mid_u", longint'(u_out), -13);
        check("rst_mid_count", longint'(spike_count), 0);
        check("rst_mid_ready", longint'(in_ready), 1);

        // four consecutive supra-threshold steps
        cnt0 = m_cnt;
        for (int i = 0; i < 4; i++) begin
            do_step("refr", 40, 1, 5, 51, -70, 6);
            check("refr_v_is_c", longint'(v_out), -70);
        end
`ifdef REFRACTORY_EN
        check("refr_total_spikes", longint'(spike_count) - cnt0, 2);
`else
        check("refr_total_spikes", longint'(spike_count) - cnt0, 4);
`endif

        // randomized steps
        for (int n = 0; n < 60; n++) begin
            r = int'($urandom_range(0, 9));
            if (r == 0)
                vn = ($urandom_range(0, 1) == 1) ? longint'($urandom_range(32768, 200000))
                                                 : -longint'($urandom_range(32769, 200000));
            else if (r < 3)
                vn = longint'($urandom_range(25, 35));
            else
                vn = longint'($urandom_range(0, 140)) - 90;
            do_step("rand", vn, $urandom_range(1, 4), $urandom_range(0, 63),
                    longint'($urandom_range(0, 255)) - 128,
                    -longint'($urandom_range(40, 80)), $urandom_range(0, 10));
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
